fetch_unit: RTL and testbench



---
 rtl/x9_pkg.sv | 23 ++
 rtl/branch_lut.sv | 21 ++
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/x9_pkg.sv
// Shared definitions for the X9 fetch/decode front end: opcodes, fetch
// sequencing states and default widths.
package x9_pkg;

    localparam int IW_DEFAULT  = 9;
    localparam int PCW_DEFAULT = 10;

    localparam logic [4:0] OP_BEQ = 5'b00101;
    localparam logic [4:0] OP_BNE = 5'b00110;
    localparam logic [4:0] OP_EQ  = 5'b01101;
    localparam logic [4:0] OP_LT  = 5'b01110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    function automatic logic is_cmp_op(input logic [4:0] op);
        return (op == OP_EQ) || (op == OP_LT);
    endfunction

endpackage

// File: rtl/branch_lut.sv
// Branch target table: 16 fixed entries of PCW bits, entry i = STRIDE * i,
// read combinationally by the 4-bit index field of a beq/bne instruction.
module branch_lut #(
    parameter int PCW    = 10,
    parameter int STRIDE = 4
) (
    input  logic [3:0]     idx_i,
    output logic [PCW-1:0] target_o
);

    // NOTE: constant table built from parameters, so there is no storage to
    // reset; it is pure decode logic and is valid from time zero.
    logic [PCW-1:0] lut_w [16];

    for (genvar i = 0; i < 16; i++) begin : g_entry
        assign lut_w[i] = PCW'(STRIDE * i);
    end

    assign target_o = lut_w[idx_i];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch / PC stage feeding the X9 control decoder: owns the PC,
// run/done sequencing and the compare flag, and picks sequential or LUT target.
module fetch_unit
    import x9_pkg::*;
#(
    parameter int PCW      = PCW_DEFAULT,
    parameter int PROG_LEN = 1024,
    parameter int IW       = IW_DEFAULT
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           Start,
    input  logic           Stall,
    input  logic [IW-1:0]  InstrIn,
    input  logic           BranchInst,
    input  logic           AluFlag,
    output logic [PCW-1:0] ProgCtr,
    output logic [IW-1:0]  InstrOut,
    output logic           InstrValid,
    output logic           CmpFlag,
    output logic           Done
);

    localparam logic [PCW:0] PROG_END = (PCW+1)'(PROG_LEN);

    fetch_state_t   state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic           flag_q, flag_d;

    logic [4:0]     opcode;
    logic [3:0]     lut_idx;
    logic [PCW-1:0] lut_target;
    logic           taken;
    logic [PCW:0]   seq_pc;
    logic [PCW:0]   next_pc;

    assign opcode  = InstrIn[IW-1 -: 5];
    assign lut_idx = InstrIn[3:0];

    branch_lut #(
        .PCW(PCW)
    ) u_branch_lut (
        .idx_i   (lut_idx),
        .target_o(lut_target)
    );

    // Flag value from before this edge decides the branch.
    assign taken = BranchInst &&
                   (((opcode == OP_BEQ) &&  flag_q) ||
                    ((opcode == OP_BNE) && !flag_q));

    // One extra bit so a step past the last PC is seen, not wrapped to 0.
    assign seq_pc  = {1'b0, pc_q} + {{PCW{1'b0}}, 1'b1};
    assign next_pc = taken ? {1'b0, lut_target} : seq_pc;

    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flag_d  = flag_q;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    flag_d  = 1'b0;
                end
            end
            RUN: begin
                if (Start) begin
                    pc_d   = '0;
                    flag_d = 1'b0;
                end else if (!Stall) begin
                    if (is_cmp_op(opcode)) begin
                        flag_d = AluFlag;
                    end
                    if (next_pc >= PROG_END) begin
                        state_d = DONE;
                    end else begin
                        pc_d = next_pc[PCW-1:0];
                    end
                end
            end
            DONE: begin
                if (Start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    flag_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
                flag_d  = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flag_q  <= flag_d;
        end
    end

    assign ProgCtr    = pc_q;
    assign CmpFlag    = flag_q;
    assign Done       = (state_q == DONE);
    assign InstrValid = (state_q == RUN) && !Stall;
    assign InstrOut   = InstrValid ? InstrIn : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scoreboarded PC/flag/done sequences
// over small ROM programs, plus a PROG_LEN = 8 straight-line run.
module tb_fetch_unit;

    localparam logic [8:0] I_ADD   = 9'h000;
    localparam logic [8:0] I_EQ    = 9'h0D0;
    localparam logic [8:0] I_BEQ3  = 9'h053;
    localparam logic [8:0] I_BNE3  = 9'h063;
    localparam logic [8:0] I_BNE15 = 9'h06F;

    typedef struct packed {
        logic [9:0] pc;
        logic       flag;
        logic       done;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    // Instance with PROG_LEN = 32 and a bench ROM
    logic       start32 = 1'b0, stall32 = 1'b0, alu32 = 1'b0, br_force = 1'b0;
    logic [8:0] rom [32];
    logic [8:0] instr32;
    logic       branch32;
    logic [9:0] pc32;
    logic [8:0] iout32;
    logic       valid32, flag32, done32;

    // Instance with PROG_LEN = 8, ROM of all add
    logic       start8 = 1'b0;
    logic       stall8 = 1'b0;
    logic       alu8   = 1'b0;
    logic       branch8 = 1'b0;
    logic [8:0] instr8 = I_ADD;
    logic [9:0] pc8;
    logic [8:0] iout8;
    logic       valid8, flag8, done8;

    always_comb begin
        instr32  = (pc32 < 10'd32) ? rom[pc32[4:0]] : I_ADD;
        branch32 = (instr32[8:4] == 5'b00101) || (instr32[8:4] == 5'b00110) || br_force;
    end

    fetch_unit #(.PCW(10), .PROG_LEN(32), .IW(9)) dut32 (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (start32),
        .Stall     (stall32),
        .InstrIn   (instr32),
        .BranchInst(branch32),
        .AluFlag   (alu32),
        .ProgCtr   (pc32),
        .InstrOut  (iout32),
        .InstrValid(valid32),
        .CmpFlag   (flag32),
        .Done      (done32)
    );

    fetch_unit #(.PCW(10), .PROG_LEN(8), .IW(9)) dut8 (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (start8),
        .Stall     (stall8),
        .InstrIn   (instr8),
        .BranchInst(branch8),
        .AluFlag   (alu8),
        .ProgCtr   (pc8),
        .InstrOut  (iout8),
        .InstrValid(valid8),
        .CmpFlag   (flag8),
        .Done      (done8)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    logic [9:0] cur_pc = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge: drive one cycle of stimulus, check this cycle's
    // valid/InstrOut, push the post-edge expectation, then pop and compare.
    task automatic tick(input logic st, input logic sl, input logic alu, input logic ev,
                        input logic [9:0] epc, input logic ef, input logic ed);
        exp_t e;
        start32 = st;
        stall32 = sl;
        alu32   = alu;
        #1;
        check("valid", 32'(valid32), 32'(ev));
        check("instr_out", 32'(iout32), ev ? 32'(rom[cur_pc[4:0]]) : 32'd0);
        sb_q.push_back('{pc: epc, flag: ef, done: ed});
        @(posedge Clk);
        @(negedge Clk);
        e = sb_q.pop_front();
        check("pc", 32'(pc32), 32'(e.pc));
        check("cmp_flag", 32'(flag32), 32'(e.flag));
        check("done", 32'(done32), 32'(e.done));
        cur_pc = e.pc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = I_ADD;
        rom[2] = I_EQ;
        rom[3] = I_BEQ3;
        rom[5] = I_EQ;
        rom[7] = I_BNE15;

        // Reset values
        #12;
        check("rst_pc", 32'(pc32), 32'd0);
        check("rst_done", 32'(done32), 32'd0);
        check("rst_valid", 32'(valid32), 32'd0);
        check("rst_iout", 32'(iout32), 32'd0);
        check("rst_flag", 32'(flag32), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;

        // Straight-line run to the end of an 8-word program
        start8 = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        start8 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("p8_pc", 32'(pc8), 32'(k));
            check("p8_valid", 32'(valid8), 32'd1);
            check("p8_done", 32'(done8), 32'd0);
            @(posedge Clk);
            @(negedge Clk);
        end
        check("p8_end_done", 32'(done8), 32'd1);
        check("p8_end_pc", 32'(pc8), 32'd7);
        check("p8_end_valid", 32'(valid8), 32'd0);
        @(posedge Clk);
        @(negedge Clk);
        check("p8_hold_pc", 32'(pc8), 32'd7);
        check("p8_hold_done", 32'(done8), 32'd1);

        // eq sets flag, beq taken 3 -> 12
        tick(1, 0, 0, 0,  0, 0, 0);
        tick(0, 0, 0, 1,  1, 0, 0);
        tick(0, 0, 0, 1,  2, 0, 0);
        tick(0, 0, 1, 1,  3, 1, 0);
        tick(0, 0, 0, 1, 12, 1, 0);
        tick(0, 0, 0, 1, 13, 1, 0);

        // Start in RUN clears flag; eq with AluFlag 0, beq not taken
        tick(1, 0, 0, 1,  0, 0, 0);
        tick(0, 0, 0, 1,  1, 0, 0);
        tick(0, 0, 0, 1,  2, 0, 0);
        tick(0, 0, 0, 1,  3, 0, 0);
        tick(0, 0, 0, 1,  4, 0, 0);

        // bne taken with flag 0; Start beats Stall; BranchInst on add ignored
        rom[3] = I_BNE3;
        tick(1, 1, 0, 0,  0, 0, 0);
        tick(0, 0, 0, 1,  1, 0, 0);
        tick(0, 0, 0, 1,  2, 0, 0);
        tick(0, 0, 0, 1,  3, 0, 0);
        tick(0, 0, 0, 1, 12, 0, 0);
        br_force = 1'b1;
        tick(0, 0, 0, 1, 13, 0, 0);
        br_force = 1'b0;

        // Stall at PC 5 (eq pending with AluFlag 0) holds flag 1 for 3 cycles
        tick(1, 0, 0, 1,  0, 0, 0);
        tick(0, 0, 0, 1,  1, 0, 0);
        tick(0, 0, 0, 1,  2, 0, 0);
        tick(0, 0, 1, 1,  3, 1, 0);
        tick(0, 0, 0, 1,  4, 1, 0);
        tick(0, 0, 0, 1,  5, 1, 0);
        for (int s = 0; s < 3; s++) tick(0, 1, 0, 0, 5, 1, 0);
        tick(0, 0, 0, 1,  6, 0, 0);

        // bne to entry 15 (target 60) beyond PROG_LEN: DONE, PC holds at 7
        tick(0, 0, 0, 1,  7, 0, 0);
        tick(0, 0, 0, 1,  7, 0, 1);
        tick(0, 0, 0, 0,  7, 0, 1);

        // Restart from DONE, run to PC 9 with flag 1 so both bne fall through
        tick(1, 0, 1, 0,  0, 0, 0);
        tick(0, 0, 1, 1,  1, 0, 0);
        tick(0, 0, 1, 1,  2, 0, 0);
        tick(0, 0, 1, 1,  3, 1, 0);
        tick(0, 0, 1, 1,  4, 1, 0);
        tick(0, 0, 1, 1,  5, 1, 0);
        tick(0, 0, 1, 1,  6, 1, 0);
        tick(0, 0, 1, 1,  7, 1, 0);
        tick(0, 0, 1, 1,  8, 1, 0);
        tick(0, 0, 1, 1,  9, 1, 0);

        // Asynchronous reset between edges
        #2;
        Reset = 1'b1;
        #1;
        check("arst_pc", 32'(pc32), 32'd0);
        check("arst_done", 32'(done32), 32'd0);
        check("arst_valid", 32'(valid32), 32'd0);
        check("arst_flag", 32'(flag32), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        cur_pc = '0;
        tick(0, 0, 0, 0,  0, 0, 0);
        tick(1, 0, 0, 0,  0, 0, 0);
        tick(0, 0, 0, 1,  1, 0, 0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
